// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the MIPS instruction fetch unit.
package mips_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO holding fetched {pc, instr} entries.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch unit with prefetch buffer and redirect drain.
// Optional FETCH_BYPASS_EN: forward a response straight to IF when the buffer is empty.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic [1:0]         Stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] IF_instr,
  output logic [ADDR_W-1:0]  IF_pc,
  output logic               IF_valid
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, resp_pc, last_pc;
  logic [CW-1:0]     outstanding, drop_cnt, drop_n, occupancy;
  logic              req_fire, resp_any, resp_run, bypass_take;
  logic              push, pop, fifo_empty, fifo_full;
  fetch_entry_t      head, push_entry;

  // Responses seen while reset is low belong to a memory that is being reset too.
  assign resp_any      = reset && imem_resp_valid;
  assign resp_run      = resp_any && (state == RUN);
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc;

`ifdef FETCH_BYPASS_EN
  assign bypass_take = fifo_empty && resp_run && (Stall == 2'b00) && !redirect_valid;
`else
  assign bypass_take = 1'b0;
`endif

  assign push       = resp_run && !redirect_valid && !bypass_take;
  assign pop        = !fifo_empty && (Stall == 2'b00) && !redirect_valid;
  assign push_entry = '{pc: resp_pc, instr: imem_resp_data};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      drop_cnt <= drop_n;
    end
  end

  // drop_cnt tracks responses still owed for requests made before the last redirect.
  always_comb begin
    state_n        = state;
    drop_n         = drop_cnt;
    imem_req_valid = 1'b0;
    IF_valid       = 1'b0;
    IF_instr       = NOP;
    IF_pc          = last_pc;
    case (state)
      RUN: begin
        imem_req_valid = reset && !redirect_valid &&
                         (({1'b0, outstanding} + {1'b0, occupancy}) < (CW + 1)'(BUF_DEPTH));
        if (redirect_valid) begin
          drop_n = outstanding - CW'(resp_any);
          if (drop_n != '0) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (resp_any) drop_n = drop_cnt - CW'(1);
        if (drop_n == '0) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
    if (!fifo_empty) begin
      IF_valid = 1'b1;
      IF_instr = head.instr;
      IF_pc    = head.pc;
    end
`ifdef FETCH_BYPASS_EN
    else if (resp_run) begin
      IF_valid = 1'b1;
      IF_instr = imem_resp_data;
      IF_pc    = resp_pc;
    end
`endif
  end

  // resp_pc is the address of the next response that will be kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
    end else begin
      if (redirect_valid) begin
        pc      <= {redirect_pc[ADDR_W-1:2], 2'b00};
        resp_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else begin
        if (req_fire) pc      <= next_pc(pc);
        if (resp_run) resp_pc <= next_pc(resp_pc);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_any && (outstanding != '0));
      if (IF_valid) last_pc <= IF_pc;
    end
  end

  buf_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: in-order memory model plus a
// count-based reference of the fetch stream, driven by directed and random steps.
module tb_mips_fetch_unit;
  import mips_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic [1:0]  Stall = 2'b00;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] IF_instr;
  logic [31:0] IF_pc;
  logic        IF_valid;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_one = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;
  logic [1:0]  w_stall = 2'b00;

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .Stall           (Stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .IF_instr        (IF_instr),
    .IF_pc           (IF_pc),
    .IF_valid        (IF_valid)
  );

  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_wrap (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (w_req_valid),
    .imem_req_ready  (w_one),
    .imem_req_addr   (w_req_addr),
    .imem_resp_valid (w_zero),
    .imem_resp_data  (w_zero32),
    .Stall           (w_stall),
    .redirect_valid  (w_zero),
    .redirect_pc     (w_zero32),
    .IF_instr        (w_instr),
    .IF_pc           (w_pc),
    .IF_valid        (w_valid)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          total = 0;
  int          bad = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          resp_pct = 100;
  logic [31:0] req_exp;
  logic [31:0] exp_pc;
  logic [31:0] last_if_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    epoch      = 0;
    buffered   = 0;
    req_exp    = RST_PC;
    exp_pc     = RST_PC;
    last_if_pc = RST_PC;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    checkOutput({tag, "_if_valid"}, 32'(IF_valid), 32'h0);
    checkOutput({tag, "_if_instr"}, IF_instr, NOP);
    checkOutput({tag, "_if_pc"}, IF_pc, RST_PC);
  endtask

  // Drive one cycle's inputs, check the outputs against the model, then advance the model.
  task automatic applyStimulus(input logic [1:0] st, input logic rdy, input logic rv,
                               input logic [31:0] rpc);
    int   old_cnt;
    int   resp_ep;
    int   lat;
    logic exp_req;
    logic exp_ifv;
    logic consumed;
    logic delivered;
    Stall           = st;
    imem_req_ready  = rdy;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    resp_ep         = -1;
    if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(0, 99) < resp_pct) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      resp_ep         = mq[0].ep;
    end
    #1;
    old_cnt = 0;
    foreach (mq[i]) if (mq[i].ep != epoch) old_cnt++;
    exp_req = (old_cnt == 0) && (mq.size() + buffered < DEPTH) && !rv;
    exp_ifv = (buffered > 0) || (BYP && resp_ep == epoch);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) checkOutput("req_addr", imem_req_addr, req_exp);
    checkOutput("if_valid", 32'(IF_valid), 32'(exp_ifv));
    if (exp_ifv) begin
      checkOutput("if_pc", IF_pc, exp_pc);
      checkOutput("if_instr", IF_instr, mem_word(exp_pc));
      last_if_pc = exp_pc;
    end else begin
      checkOutput("if_instr_nop", IF_instr, NOP);
      checkOutput("if_pc_hold", IF_pc, last_if_pc);
    end
    consumed  = exp_ifv && (st == 2'b00) && !rv;
    delivered = imem_resp_valid && (resp_ep == epoch) && !rv;
    if (imem_resp_valid) void'(mq.pop_front());
    if (imem_req_valid && rdy) begin
      lat = $urandom_range(lat_min, lat_max);
      mq.push_back('{addr: imem_req_addr, due: cyc + lat, ep: epoch});
      req_exp = req_exp + 32'd4;
    end
    if (rv) begin
      epoch++;
      buffered = 0;
      exp_pc   = rpc;
      req_exp  = rpc;
    end else begin
      buffered = buffered + int'(delivered) - int'(consumed);
      if (consumed) exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    reset           = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    #1;
    checkResetOutputs(tag);
    @(negedge clk);
    modelReset();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [1:0]  st;
    modelReset();
    // Response offered while held in reset must never appear.
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("por");
    checkOutput("wrap_rst_req_valid", 32'(w_req_valid), 32'h0);
    @(negedge clk);
    imem_resp_valid = 1'b0;

    $display("[TB] reset release, 1-cycle memory, no stall");
    reset = 1'b1;
    #1;
    checkOutput("wrap_addr0", w_req_addr, 32'hFFFF_FFF8);
    checkOutput("wrap_valid0", 32'(w_req_valid), 32'h1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_addr1", w_req_addr, 32'hFFFF_FFFC);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_addr2", w_req_addr, 32'h0000_0000);
    for (int i = 0; i < 10; i++) applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);

    $display("[TB] stall held with buffer full");
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);

    $display("[TB] memory not ready for 4 cycles");
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);

    $display("[TB] redirect with two requests outstanding");
    doReset("rst_a");
    lat_min = 5;
    lat_max = 5;
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 14; i++) applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);

    $display("[TB] reset asserted while draining");
    doReset("rst_b");
    lat_min = 6;
    lat_max = 6;
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h0000_0200);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);
    #2;
    doReset("drain_rst");
    for (int i = 0; i < 6; i++) applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);

    $display("[TB] randomized traffic");
    lat_min  = 1;
    lat_max  = 4;
    resp_pct = 75;
    for (int i = 0; i < 800; i++) begin
      rnd = $urandom;
      st  = ($urandom_range(0, 99) < 20) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(st, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 4),
                    {rnd[31:2], 2'b00});
    end
    resp_pct = 100;
    lat_min  = 1;
    lat_max  = 1;
    for (int i = 0; i < 20; i++) applyStimulus(2'b00, 1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
